// File: rtl/dataflow_router.sv
// dataflow_router: two-stage lane router. S1 captures a vector with its mode and
// select; S2 holds the transformed, registered output. SEQ mode replays S1 as
// one broadcast beat per lane before S1 is released.
//
// state | meaning
// IDLE  | S1 empty, ready to accept
// HOLD  | S1 full with a single-beat (BCAST/PASS/ROT) transaction
// SEQ   | S1 full, beat counter walking lanes 0..LANE-1
module dataflow_router #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int LANE  = 512,
  parameter int WORDS = 16,
  localparam int W    = IL + FL,
  localparam int SW   = ($clog2(LANE) < 1) ? 1 : $clog2(LANE)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [1:0]                             mode,
  input  logic [SW-1:0]                          sel,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [LANE-1:0][WORDS-1:0][W-1:0] in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [LANE-1:0][WORDS-1:0][W-1:0] out,
  output logic [SW-1:0]                          out_beat,
  output logic                                   out_last
);

  localparam logic [1:0] M_BCAST = 2'd0;
  localparam logic [1:0] M_PASS  = 2'd1;
  localparam logic [1:0] M_ROT   = 2'd2;
  localparam logic [1:0] M_SEQ   = 2'd3;
  localparam logic [SW-1:0] BEAT_MAX = SW'(LANE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SEQ} state_t;

  state_t state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0] mode_q;
  logic [SW-1:0] sel_q;
  logic signed [LANE-1:0][WORDS-1:0][W-1:0] s1_q;

  logic s2_valid_q;
  logic signed [LANE-1:0][WORDS-1:0][W-1:0] s2_data_q, s2_data_d;
  logic [SW-1:0] s2_beat_q, s2_beat_d;
  logic s2_last_q, s2_last_d;

  logic s1_full, s2_load, beat_last, s1_retire, accept;
  logic [SW-1:0] bcast_idx;

  assign s1_full   = (state_q != ST_IDLE);
  assign s2_load   = s1_full && (!s2_valid_q || out_ready);
  assign beat_last = (state_q != ST_SEQ) || (cnt_q == BEAT_MAX);
  assign s1_retire = s2_load && beat_last;
  assign in_ready  = !reset && (!s1_full || s1_retire);
  assign accept    = in_valid && in_ready;
  assign bcast_idx = SW'(int'(sel_q) % LANE);

  assign out_valid = s2_valid_q;
  assign out       = s2_data_q;
  assign out_beat  = s2_beat_q;
  assign out_last  = s2_last_q;

  // Control state and SEQ beat counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave on retire, re-enter on accept (same-cycle handoff allowed)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (s2_load && state_q == ST_SEQ) begin
      cnt_d = beat_last ? '0 : cnt_q + SW'(1);
    end
    if (s1_retire) begin
      state_d = ST_IDLE;
    end
    if (accept) begin
      state_d = (mode == M_SEQ) ? ST_SEQ : ST_HOLD;
    end
  end

  // S1 capture of vector, mode and select on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      mode_q <= M_BCAST;
      sel_q  <= '0;
    end else if (accept) begin
      s1_q   <= in;
      mode_q <= mode;
      sel_q  <= sel;
    end
  end

  // Lane transform of the captured S1 vector; words move bit-exact
  always_comb begin
    s2_data_d = '0;
    s2_beat_d = '0;
    s2_last_d = 1'b1;
    case (mode_q)
      M_BCAST: begin
        for (int i = 0; i < LANE; i++) s2_data_d[i] = s1_q[bcast_idx];
      end
      M_PASS: begin
        s2_data_d = s1_q;
      end
      M_ROT: begin
        for (int i = 0; i < LANE; i++) s2_data_d[i] = s1_q[SW'((i + int'(sel_q)) % LANE)];
      end
      default: begin
        for (int i = 0; i < LANE; i++) s2_data_d[i] = s1_q[cnt_q];
        s2_beat_d = cnt_q;
        s2_last_d = (cnt_q == BEAT_MAX);
      end
    endcase
  end

  // S2 output register: load from S1 when free or draining, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_beat_q  <= '0;
      s2_last_q  <= 1'b1;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      s2_data_q  <= s2_data_d;
      s2_beat_q  <= s2_beat_d;
      s2_last_q  <= s2_last_d;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dataflow_router.sv
// Directed bench for dataflow_router with LANE=4, WORDS=2, W=20.
module tb_dataflow_router;

  typedef logic signed [3:0][1:0][19:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] sel = 2'd0;
  logic in_valid = 1'b0;
  logic in_ready;
  vec_t din = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  vec_t dout;
  logic [1:0] out_beat;
  logic out_last;

  int tests_run = 0;
  int tests_failed = 0;

  dataflow_router #(.IL(4), .FL(16), .LANE(4), .WORDS(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout),
    .out_beat(out_beat), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3);
    vec_t v;
    v[0][0] = 20'(a0); v[1][0] = 20'(a1); v[2][0] = 20'(a2); v[3][0] = 20'(a3);
    v[0][1] = 20'(b0); v[1][1] = 20'(b1); v[2][1] = 20'(b2); v[3][1] = 20'(b3);
    return v;
  endfunction

  function automatic vec_t pv(input int n);
    return mk(n*16, n*16+1, n*16+2, n*16+3, -(n*16), -(n*16+1), -(n*16+2), -(n*16+3));
  endfunction

  initial begin
    vec_t va, vb, held;
    int sent, recv;
    logic saw_low, hold_chk, acc;

    // reset: in_ready low even with in_valid high, nothing accepted
    in_valid = 1'b1; din = pv(9); mode = 2'd1;
    #1;
    chk("rst_in_ready", 160'(in_ready), 160'(0));
    step(); step();
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out", dout, 160'(0));
    chk("rst_beat", 160'(out_beat), 160'(0));
    chk("rst_last", 160'(out_last), 160'(1));
    in_valid = 1'b0;
    reset = 1'b0;
    step(); step();
    chk("rst_no_accept", 160'(out_valid), 160'(0));

    // BCAST sel=2, lane2 = {7,-3}
    va = mk(1, 3, 7, 5, 2, 4, -3, 6);
    din = va; mode = 2'd0; sel = 2'd2; in_valid = 1'b1;
    #1;
    chk("bc_in_ready", 160'(in_ready), 160'(1));
    step();
    in_valid = 1'b0;
    chk("bc_lat1", 160'(out_valid), 160'(0));
    step();
    chk("bc_valid", 160'(out_valid), 160'(1));
    chk("bc_data", dout, mk(7, 7, 7, 7, -3, -3, -3, -3));
    chk("bc_last", 160'(out_last), 160'(1));
    chk("bc_beat", 160'(out_beat), 160'(0));
    step();
    chk("bc_drain", 160'(out_valid), 160'(0));

    // ROT back-to-back: sel=1 then sel=5 (wraps to 1) then sel=3
    va = mk(10, 11, 12, 13, 20, 21, 22, 23);
    din = va; mode = 2'd2; sel = 2'd1; in_valid = 1'b1;
    step();
    sel = 2'(5);
    step();
    chk("rot1_data", dout, mk(11, 12, 13, 10, 21, 22, 23, 20));
    sel = 2'd3;
    step();
    chk("rot5_data", dout, mk(11, 12, 13, 10, 21, 22, 23, 20));
    in_valid = 1'b0;
    step();
    chk("rot3_valid", 160'(out_valid), 160'(1));
    chk("rot3_data", dout, mk(13, 10, 11, 12, 23, 20, 21, 22));
    step();
    chk("rot_drain", 160'(out_valid), 160'(0));

    // SEQ: four broadcast beats; mode/sel changes after capture are ignored
    va = mk(1, 2, 3, 4, -1, -2, -3, -4);
    din = va; mode = 2'd3; sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mode = 2'd1; sel = 2'd3;
    chk("seq_rdy0", 160'(in_ready), 160'(0));
    step();
    chk("seq_b0", dout, mk(1, 1, 1, 1, -1, -1, -1, -1));
    chk("seq_b0_beat", 160'(out_beat), 160'(0));
    chk("seq_b0_last", 160'(out_last), 160'(0));
    chk("seq_rdy1", 160'(in_ready), 160'(0));
    step();
    chk("seq_b1", dout, mk(2, 2, 2, 2, -2, -2, -2, -2));
    chk("seq_b1_beat", 160'(out_beat), 160'(1));
    chk("seq_rdy2", 160'(in_ready), 160'(0));
    step();
    chk("seq_b2", dout, mk(3, 3, 3, 3, -3, -3, -3, -3));
    chk("seq_b2_last", 160'(out_last), 160'(0));
    chk("seq_rdy3", 160'(in_ready), 160'(1));
    step();
    chk("seq_b3", dout, mk(4, 4, 4, 4, -4, -4, -4, -4));
    chk("seq_b3_beat", 160'(out_beat), 160'(3));
    chk("seq_b3_last", 160'(out_last), 160'(1));
    step();
    chk("seq_drain", 160'(out_valid), 160'(0));

    // backpressure: PASS stream of 5, out_ready low for cycles 3..5
    sent = 0; recv = 0; saw_low = 1'b0; hold_chk = 1'b0; held = '0;
    mode = 2'd1;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      out_ready = !(c >= 3 && c < 6);
      in_valid = (sent < 5);
      din = pv(sent);
      #1;
      if (!in_ready) saw_low = 1'b1;
      if (hold_chk) chk("bp_stable", dout, held);
      hold_chk = out_valid && !out_ready;
      held = dout;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_data%0d", recv), dout, pv(recv));
        recv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 160'(recv), 160'(5));
    chk("bp_ready_dropped", 160'(saw_low), 160'(1));
    step();
    chk("bp_drain", 160'(out_valid), 160'(0));

    // reset during SEQ beat 1, then a clean PASS vector
    din = mk(5, 6, 7, 8, 9, 10, 11, 12); mode = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("rs_beat1", 160'(out_beat), 160'(1));
    reset = 1'b1;
    #1;
    chk("rs_in_ready", 160'(in_ready), 160'(0));
    step();
    chk("rs_valid", 160'(out_valid), 160'(0));
    chk("rs_out", dout, 160'(0));
    chk("rs_last", 160'(out_last), 160'(1));
    reset = 1'b0;
    step(); step();
    chk("rs_no_resume", 160'(out_valid), 160'(0));
    vb = mk(-100, 200, -300, 400, 524287, -524288, 1, -1);
    din = vb; mode = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rs_pass_lat", 160'(out_valid), 160'(0));
    step();
    chk("rs_pass_valid", 160'(out_valid), 160'(1));
    chk("rs_pass_data", dout, vb);
    step();

    // back-to-back PASS then BCAST (sel=0)
    va = mk(21, 22, 23, 24, 31, 32, 33, 34);
    vb = mk(-5, 40, 41, 42, 6, 50, 51, 52);
    din = va; mode = 2'd1; sel = 2'd3; in_valid = 1'b1;
    step();
    din = vb; mode = 2'd0; sel = 2'd0;
    #1;
    chk("b2b_in_ready", 160'(in_ready), 160'(1));
    step();
    in_valid = 1'b0; mode = 2'd2; sel = 2'd1;
    chk("b2b_pass", dout, va);
    step();
    chk("b2b_bcast_valid", 160'(out_valid), 160'(1));
    chk("b2b_bcast", dout, mk(-5, -5, -5, -5, 6, 6, 6, 6));
    step();
    chk("b2b_drain", 160'(out_valid), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dataflow_router.md
DATAFLOW_ROUTER -- requirements
Module: dataflow_router

Interface
REQ-001 SHALL have parameter IL, default 4: integer bits per word.
REQ-002 SHALL have parameter FL, default 16: fraction bits per word; word width W = IL+FL, signed.
REQ-003 SHALL have parameter LANE, default 512: lane count, at least 2.
REQ-004 SHALL have parameter WORDS, default 16: words per lane.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port mode, input, 2: transform select, sampled with in_valid. 0=BCAST, 1=PASS, 2=ROT, 3=SEQ.
REQ-008 SHALL have port sel, input, SW = max(1, clog2(LANE)): source lane for BCAST, rotate amount for ROT; ignored otherwise.
REQ-009 SHALL have port in_valid, input, 1: input vector valid.
REQ-010 SHALL have port in_ready, output, 1: block accepts the input vector.
REQ-011 SHALL have port in, input, signed W x [LANE][WORDS]: input vector.
REQ-012 SHALL have port out_valid, output, 1: output vector valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the output vector.
REQ-014 SHALL have port out, output, signed W x [LANE][WORDS]: output vector, registered.
REQ-015 SHALL have port out_beat, output, SW: in SEQ mode, index of the broadcast lane; 0 in other modes.
REQ-016 SHALL have port out_last, output, 1: final beat of the transaction; always 1 in non-SEQ modes.

Function
REQ-017 SHALL accept a transaction on a cycle with in_valid && in_ready, capturing in, mode and sel into stage S1.
REQ-018 SHALL transfer an output on a cycle with out_valid && out_ready.
REQ-019 SHALL keep out, out_beat and out_last stable while out_valid=1 && out_ready=0.
REQ-020 SHALL drive in_ready = !reset && (S1 empty || S1 retires this cycle); combinational, no dependency on in_valid.
REQ-021 SHALL load output stage S2 from S1 when S2 is empty or S2 transfers this cycle.
REQ-022 SHALL give latency from acceptance edge to out_valid=1 of exactly 2 cycles when unstalled; full throughput of 1 vector/cycle in non-SEQ modes.
REQ-023 SHALL, in BCAST mode, set out[i][k] = S1.in[sel][k] for all i and k. A sel value >= LANE SHALL be taken modulo LANE.
REQ-024 SHALL, in PASS mode, set out[i][k] = S1.in[i][k].
REQ-025 SHALL, in ROT mode, set out[i][k] = S1.in[(i+sel) mod LANE][k].
REQ-026 SHALL, in SEQ mode, emit LANE beats b = 0..LANE-1 in order, with beat b setting out[i][k] = S1.in[b][k] for all i, out_beat=b, and out_last=(b==LANE-1).
REQ-027 SHALL retire S1 only when its last beat loads into S2. During a SEQ transaction in_ready SHALL be 0 until the beat LANE-1 load cycle.
REQ-028 SHALL hold the SEQ beat counter in S1 control: it increments on each beat load into S2, wraps to 0 at retire, and holds under backpressure.
REQ-029 SHALL use control states IDLE (S1 empty), HOLD (S1 full, non-SEQ) and SEQ (S1 full, beat counter active); transitions occur only on acceptance or retire.
REQ-030 SHALL accept a new transaction in the same cycle the previous one retires, with no bubble.
REQ-031 SHALL NOT apply arithmetic to data: words are moved bit-exact, with no saturation or sign change.
REQ-032 SHALL ignore mode and sel changes while S1 is full; only the captured values apply.

Reset
REQ-033 SHALL, while reset=1 at a clock edge, clear S1 and S2 data to 0, out to all-zero, out_valid to 0, out_beat to 0, out_last to 1, state to IDLE and the beat counter to 0.
REQ-034 SHALL hold in_ready at 0 while reset=1, and accept no transaction on that cycle.
REQ-035 SHALL abandon any in-flight transaction, including a partial SEQ, on reset assertion; no beat of it is emitted afterwards.

Verification
REQ-036 SHALL cover BCAST (LANE=4, WORDS=2, lane2 = {7,-3}, sel=2, out_ready=1) -> 2 cycles after accept, every lane = {7,-3}, out_last=1.
REQ-037 SHALL cover ROT (lanes 0..3 word0 = 10,11,12,13; sel=1) -> out word0 = 11,12,13,10. sel=5 gives the same result.
REQ-038 SHALL cover SEQ (lanes word0 = 1,2,3,4; out_ready=1) -> 4 consecutive beats broadcasting 1,2,3,4, out_beat 0..3, out_last only on beat 3, and in_ready low for 3 cycles.
REQ-039 SHALL cover backpressure (PASS stream of 5 vectors, out_ready low for 3 cycles mid-stream) -> at most 2 vectors buffered, in_ready drops, out stable, no loss or duplication, order preserved.
REQ-040 SHALL cover reset in the middle of SEQ beat 1 -> next cycle out_valid=0 and out=0; after release a new PASS vector emerges intact 2 cycles after accept.
REQ-041 SHALL cover back-to-back PASS then BCAST with out_ready=1 -> both accepted on consecutive cycles and output on consecutive cycles, each with its own captured mode.
